// File: rtl/time_keeper.sv
// time_keeper: hh:mm:ss counter with a button-driven set mode.
// Ports: clk, reset (sync, active-low), tick_1hz, btn_mode, btn_inc,
//   btn_long in; t_s, t_m, t_h, set_time, sec_pulse out (all registered).
module time_keeper #(
  parameter int unsigned REPEAT_CYCLES = 25_000_000,
  parameter int unsigned SET_TIMEOUT   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_long,
  output logic [5:0] t_s,
  output logic [5:0] t_m,
  output logic [4:0] t_h,
  output logic [2:0] set_time,
  output logic       sec_pulse
);

  typedef enum logic [1:0] {
    RUN, SET_S, SET_M, SET_H
  } state_e;

  localparam logic [24:0] REP_MAX = 25'(REPEAT_CYCLES - 1);
  localparam logic [3:0]  TO_MAX  = 4'(SET_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [24:0] rep_q, rep_d;
  logic [3:0]  idle_q, idle_d;
  logic [5:0]  s_q, s_d, m_q, m_d;
  logic [4:0]  h_q, h_d;
  logic [2:0]  set_q, set_d;
  logic        adv_q, adv_d;
  logic        pulse_q;

  logic in_set, strobe, inc_ev, timeout;

  always_comb begin
    state_d = state_q;
    rep_d   = '0;
    idle_d  = '0;
    s_d     = s_q;
    m_d     = m_q;
    h_d     = h_q;
    set_d   = '0;
    timeout = 1'b0;

    in_set = (state_q != RUN);
    strobe = in_set && btn_long && (rep_q == REP_MAX);
    // Mode press wins over any increment on the same edge.
    inc_ev = in_set && (btn_inc || strobe) && !btn_mode;
    adv_d  = !in_set && tick_1hz;

    if (in_set && btn_long && !strobe)
      rep_d = rep_q + 25'd1;

    if (in_set && !btn_mode && !btn_inc && !btn_long) begin
      idle_d = idle_q;
      if (tick_1hz) begin
        if (idle_q == TO_MAX) begin
          idle_d  = '0;
          timeout = 1'b1;
        end else begin
          idle_d = idle_q + 4'd1;
        end
      end
    end

    // Running: full carry chain.
    if (adv_d) begin
      if (s_q == 6'd59) begin
        s_d = '0;
        if (m_q == 6'd59) begin
          m_d = '0;
          h_d = (h_q == 5'd23) ? '0 : h_q + 5'd1;
        end else begin
          m_d = m_q + 6'd1;
        end
      end else begin
        s_d = s_q + 6'd1;
      end
    end

    // Setting: selected field only, no carry.
    if (inc_ev) begin
      unique case (state_q)
        SET_S:   s_d = (s_q == 6'd59) ? '0 : s_q + 6'd1;
        SET_M:   m_d = (m_q == 6'd59) ? '0 : m_q + 6'd1;
        SET_H:   h_d = (h_q == 5'd23) ? '0 : h_q + 5'd1;
        default: ;
      endcase
    end

    if (btn_mode) begin
      unique case (state_q)
        RUN:     state_d = SET_S;
        SET_S:   state_d = SET_M;
        SET_M:   state_d = SET_H;
        default: state_d = RUN;
      endcase
    end else if (timeout) begin
      state_d = RUN;
    end

    unique case (state_d)
      SET_S:   set_d = 3'b001;
      SET_M:   set_d = 3'b010;
      SET_H:   set_d = 3'b100;
      default: set_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      rep_q   <= '0;
      idle_q  <= '0;
      s_q     <= '0;
      m_q     <= '0;
      h_q     <= '0;
      set_q   <= '0;
      adv_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      idle_q  <= idle_d;
      s_q     <= s_d;
      m_q     <= m_d;
      h_q     <= h_d;
      set_q   <= set_d;
      adv_q   <= adv_d;
      // One cycle behind the visible time update.
      pulse_q <= adv_q;
    end
  end

  assign t_s       = s_q;
  assign t_m       = m_q;
  assign t_h       = h_q;
  assign set_time  = set_q;
  assign sec_pulse = pulse_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: scoreboard bench for time_keeper.
// Ports: none (drives clk/reset and buttons, checks all outputs).
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_long = 1'b0;
  logic [5:0] t_s, t_m;
  logic [4:0] t_h;
  logic [2:0] set_time;
  logic       sec_pulse;

  int tests = 0;
  int fails = 0;
  int npulse = 0;

  typedef struct {
    int s, m, h, st, p;
  } exp_t;

  exp_t sb[$];

  int ms = 0, mm = 0, mh = 0, mset = 0, midle = 0, mp1 = 0;

  time_keeper #(
    .REPEAT_CYCLES(4),
    .SET_TIMEOUT  (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .btn_long (btn_long),
    .t_s      (t_s),
    .t_m      (t_m),
    .t_h      (t_h),
    .set_time (set_time),
    .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("t_s", 32'(t_s), e.s);
    chk("t_m", 32'(t_m), e.m);
    chk("t_h", 32'(t_h), e.h);
    chk("set_time", 32'(set_time), e.st);
    chk("sec_pulse", 32'(sec_pulse), e.p);
    if (sec_pulse) npulse++;
  endtask

  // st: the bench-known auto-repeat strobe for this edge.
  task automatic cyc(input logic tk, input logic md, input logic inc,
                     input logic lg, input logic st);
    exp_t e;
    int np1;
    np1 = (mset == 0 && tk) ? 1 : 0;
    if (mset == 0) begin
      if (tk) begin
        if (ms == 59) begin
          ms = 0;
          if (mm == 59) begin
            mm = 0;
            mh = (mh == 23) ? 0 : mh + 1;
          end else mm++;
        end else ms++;
      end
      if (md) mset = 1;
    end else if (md) begin
      mset = (mset == 4) ? 0 : mset << 1;
      midle = 0;
    end else begin
      if (inc || st) begin
        case (mset)
          1: ms = (ms == 59) ? 0 : ms + 1;
          2: mm = (mm == 59) ? 0 : mm + 1;
          default: mh = (mh == 23) ? 0 : mh + 1;
        endcase
      end
      if (inc || lg) midle = 0;
      else if (tk) begin
        midle++;
        if (midle == 3) begin
          mset = 0;
          midle = 0;
        end
      end
    end
    e.s = ms; e.m = mm; e.h = mh; e.st = mset; e.p = mp1;
    mp1 = np1;
    sb.push_back(e);
    tick_1hz = tk; btn_mode = md; btn_inc = inc; btn_long = lg;
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic rst_cyc(input logic lg);
    exp_t e;
    ms = 0; mm = 0; mh = 0; mset = 0; midle = 0; mp1 = 0;
    e.s = 0; e.m = 0; e.h = 0; e.st = 0; e.p = 0;
    sb.push_back(e);
    reset = 1'b0; btn_long = lg;
    tick_1hz = 0; btn_mode = 0; btn_inc = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    pop_cmp();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst_cyc(0);

    // 61 ticks from reset
    npulse = 0;
    for (int i = 0; i < 61; i++) begin
      cyc(1, 0, 0, 0, 0);
      idle();
    end
    chk("t1_s", 32'(t_s), 1);
    chk("t1_m", 32'(t_m), 1);
    chk("t1_h", 32'(t_h), 0);
    chk("t1_pulses", npulse, 61);

    // preload 23:59:58 via the set path
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 57; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 58; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 23; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("t2_pre", {t_h, t_m, t_s}, {5'd23, 6'd59, 6'd58});
    cyc(1, 0, 0, 0, 0);
    chk("t2_59", {t_h, t_m, t_s}, {5'd23, 6'd59, 6'd59});
    idle();
    cyc(1, 0, 0, 0, 0);
    chk("t2_wrap", {t_h, t_m, t_s}, 17'd0);
    idle();

    // bring to 00:00:05 then 60 increments in SET_S with ticks
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      idle();
    end
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      cyc(0, 0, 1, 0, 0);
      if (i % 10 == 9) cyc(1, 0, 0, 0, 0);
    end
    chk("t3_set", 32'(set_time), 1);
    chk("t3_s", 32'(t_s), 5);
    chk("t3_m", 32'(t_m), 0);

    // SET_H auto-repeat, steps every 4 cycles
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 1; i <= 12; i++) cyc(0, 0, 0, 1, (i % 4 == 0));
    chk("t4_h", 32'(t_h), 3);
    idle();
    cyc(0, 1, 1, 0, 0);
    chk("t4_run", 32'(set_time), 0);
    chk("t4_noinc", 32'(t_h), 3);

    // idle timeout in SET_M
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle();
    cyc(1, 0, 0, 0, 0);
    idle();
    chk("t5_still", 32'(set_time), 2);
    cyc(1, 0, 0, 0, 0);
    chk("t5_run", 32'(set_time), 0);
    chk("t5_s", 32'(t_s), 5);
    idle();

    // reset during SET_S auto-repeat
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    rst_cyc(1);
    chk("t6_zero", {set_time, t_h, t_m, t_s}, 20'd0);
    idle();
    cyc(1, 0, 0, 0, 0);
    chk("t6_s", 32'(t_s), 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
